alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked successor to the team's combinational 4-bit ALU. It registers results and flags, adds XOR, shift and sequential multiply operations, and adds a signed-overflow flag. It sits between an operand source and a result consumer using valid/ready on both sides. It processes one operation at a time: single-cycle ops complete in one cycle and MUL iterates for WIDTH cycles.

## Interface
- `WIDTH`, default 8: operand/result width, must be ≥ 4 and a power of two.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands and op presented.
- `in_ready` output 1: block accepts on `in_valid && in_ready` at a rising edge.
- `a`, `b` input WIDTH each: operands, unsigned bit vectors; signed view used only for `v`.
- `op` input 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- `out_valid` output 1: result and flags valid.
- `out_ready` input 1: consumer takes the result on `out_valid && out_ready`.
- `y` output WIDTH: result.
- `z`, `n`, `c`, `v` output 1 each: zero, negative (`y[WIDTH-1]`), carry/borrow, signed overflow.

## Operation
- FSM states: IDLE, BUSY (MUL iterating), DONE (result held).
- IDLE with accept: a non-MUL op goes to DONE with result registered. MUL goes to BUSY with the iteration counter at 0.
- BUSY: one shift-add step per cycle. After WIDTH steps, go to DONE. Inputs are ignored.
- DONE with `out_ready`: if `in_valid` the next op is accepted in the same cycle (back-to-back), otherwise go to IDLE. DONE without `out_ready`: hold everything.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). It is combinational from `out_ready`.
- Arithmetic is computed at WIDTH+1 bits.
  - ADD: `c` = bit WIDTH of a+b. `v` = operand signs equal and result sign differs.
  - SUB: `c` = borrow (a<b unsigned). `v` = operand signs differ and result sign differs from `a`.
  - AND, OR, XOR: `c`=0, `v`=0.
  - SHL/SHR: shift amount is `b[log2(WIDTH)-1:0]`, logical. `c` = last bit shifted out, or 0 if the amount is 0. `v`=0.
  - MUL: unsigned, full 2·WIDTH product computed internally. `y` = low WIDTH bits. `c` = 1 if the high half is nonzero. `v`=0.
- `z` and `n` are always derived from the final `y`.
- Operands and op are captured at acceptance, so input changes afterwards have no effect.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `y`=0, `z`=1, `n`=`c`=`v`=0, multiplier counter and accumulator 0.
- Reset wins over every other event, including mid-MUL and DONE-with-accept. The next cycle shows reset values.
- Non-MUL op accepted at edge k: `out_valid`=1 after edge k+1 is not the rule. It is 1 immediately after edge k (registered result).
- MUL accepted at edge k: `out_valid`=1 after edge k+WIDTH. `in_ready`=0 for those WIDTH cycles.
- `y` and the flags are stable whenever `out_valid`=1 and the result is not consumed.
- Throughput: one non-MUL op per cycle with `out_ready` held high.

## Structure
- `alu_pkg`: `op_t` enum (3-bit codes above), `state_t` enum (IDLE/BUSY/DONE), and function `clog2`-based shift-amount width constant.
- Sub-module `alu_mul_seq`: WIDTH-parametrised shift-add multiplier with `start`, `done`, and a 2·WIDTH product. It owns the counter and accumulator.
- The top level holds the FSM, the single-cycle datapath, and the output/flag registers.

## Test plan
- WIDTH=8, ADD 0xFF+0x01 → `y`=0x00, `z`=1, `c`=1, `n`=0, `v`=0; `out_valid` the cycle after accept.
- SUB 0x03−0x05 → `y`=0xFE, `c`=1, `n`=1, `v`=0. SUB 0x80−0x01 → `y`=0x7F, `v`=1, `c`=0.
- MUL 0x10×0x10 → `y`=0x00, `z`=1, `c`=1. `out_valid` 8 cycles after accept, with `in_ready`=0 throughout.
- SHR 0x81 by 1 → `y`=0x40, `c`=1. SHL 0x81 by 0 → `y`=0x81, `c`=0, `n`=1.
- Hold `out_ready`=0 for 3 cycles in DONE → `y`/flags unchanged and `in_ready`=0. Then raise `out_ready` with `in_valid`=1 → back-to-back accept in the same cycle.
- Assert `rst` at the 4th cycle of a MUL → the next cycle shows `out_valid`=0, `in_ready`=1, `y`=0, `z`=1; a fresh ADD then completes normally.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared types and helpers for the pipelined ALU and its sequential multiplier.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed for a shift amount (and the multiplier step counter) at a given width.
  function automatic int shamt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between source, ALU and consumer.
interface alu_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_t              op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             z;
  logic             n;
  logic             c;
  logic             v;

  // Source/consumer side.
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, z, n, c, v
  );

  // ALU side.
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, z, n, c, v
  );
endinterface

// File: rtl/alu_pipe_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH steps.
// The product output is the accumulator including the current step, so it is
// the full result in the cycle where done is high.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int               CNT_W = shamt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic               busy_reg;

  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign done     = busy_reg && (cnt_reg == LAST);
  assign product  = acc_next;

  // Capture operands on start, then shift multiplicand left / multiplier right each step.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      if (cnt_reg == LAST) begin
        busy_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: registered result and flags, single-cycle ops plus an iterative MUL.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  alu_pipe_if.slave bus
);
  localparam int SHW = shamt_width(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_t             state_reg;
  logic               out_valid_reg;
  logic [WIDTH-1:0]   y_reg;
  logic               z_reg, n_reg, c_reg, v_reg;

  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   shl_tab [WIDTH];
  logic [WIDTH-1:0]   shr_tab [WIDTH];
  logic [WIDTH-1:0]   shl_c_tab;
  logic [WIDTH-1:0]   shr_c_tab;

  logic [WIDTH-1:0]   alu_y;
  logic               alu_c, alu_v;
  logic [WIDTH-1:0]   res_y_next;
  logic               res_c_next, res_v_next;

  assign bus.in_ready = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign mul_start    = accept && (bus.op == OP_MUL);

  assign sum_w  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff_w = {1'b0, bus.a} - {1'b0, bus.b};
  assign shamt  = bus.b[SHW-1:0];

  // Per-amount shift results and the last bit shifted out; amount 0 shifts nothing out.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_zero
        assign shl_tab[gi]   = bus.a;
        assign shr_tab[gi]   = bus.a;
        assign shl_c_tab[gi] = 1'b0;
        assign shr_c_tab[gi] = 1'b0;
      end else begin : g_amt
        assign shl_tab[gi]   = bus.a << gi;
        assign shr_tab[gi]   = bus.a >> gi;
        assign shl_c_tab[gi] = bus.a[WIDTH-gi];
        assign shr_c_tab[gi] = bus.a[gi-1];
      end
    end
  endgenerate

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath on the presented operands.
  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_y = sum_w[MSB:0];
        alu_c = sum_w[WIDTH];
        alu_v = (bus.a[MSB] == bus.b[MSB]) && (sum_w[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        alu_y = diff_w[MSB:0];
        alu_c = diff_w[WIDTH];
        alu_v = (bus.a[MSB] != bus.b[MSB]) && (diff_w[MSB] != bus.a[MSB]);
      end
      OP_AND: alu_y = bus.a & bus.b;
      OP_OR:  alu_y = bus.a | bus.b;
      OP_XOR: alu_y = bus.a ^ bus.b;
      OP_SHL: begin
        alu_y = shl_tab[shamt];
        alu_c = shl_c_tab[shamt];
      end
      OP_SHR: begin
        alu_y = shr_tab[shamt];
        alu_c = shr_c_tab[shamt];
      end
      default: ;
    endcase
  end

  // Pick the value to register: multiplier result while iterating, else the ALU.
  always_comb begin
    res_y_next = alu_y;
    res_c_next = alu_c;
    res_v_next = alu_v;
    if (state_reg == BUSY) begin
      res_y_next = mul_product[MSB:0];
      res_c_next = |mul_product[2*WIDTH-1:WIDTH];
      res_v_next = 1'b0;
    end
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      y_reg         <= '0;
      z_reg         <= 1'b1;
      n_reg         <= 1'b0;
      c_reg         <= 1'b0;
      v_reg         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            if (bus.op == OP_MUL) begin
              state_reg     <= BUSY;
              out_valid_reg <= 1'b0;
            end else begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              y_reg         <= res_y_next;
              z_reg         <= (res_y_next == '0);
              n_reg         <= res_y_next[MSB];
              c_reg         <= res_c_next;
              v_reg         <= res_v_next;
            end
          end else if ((state_reg == DONE) && bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        BUSY: begin
          if (mul_done) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            y_reg         <= res_y_next;
            z_reg         <= (res_y_next == '0);
            n_reg         <= res_y_next[MSB];
            c_reg         <= res_c_next;
            v_reg         <= res_v_next;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.y         = y_reg;
  assign bus.z         = z_reg;
  assign bus.n         = n_reg;
  assign bus.c         = c_reg;
  assign bus.v         = v_reg;
endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe against an arithmetic reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W    = 8;
  localparam int FULL = 1 << W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Expected {y,z,n,c,v} from plain integer arithmetic and signed range checks.
  function automatic logic [W+3:0] model(input op_t o, input int a, input int b);
    int sa, sb, r, amt;
    longint p;
    logic [W-1:0] y;
    logic c, v;
    sa  = (a >= FULL / 2) ? a - FULL : a;
    sb  = (b >= FULL / 2) ? b - FULL : b;
    amt = b % W;
    y = '0; c = 1'b0; v = 1'b0;
    case (o)
      OP_ADD: begin
        r = a + b;  y = W'(r % FULL); c = (r >= FULL);
        v = ((sa + sb) >= FULL / 2) || ((sa + sb) < -(FULL / 2));
      end
      OP_SUB: begin
        r = a - b + FULL; y = W'(r % FULL); c = (a < b);
        v = ((sa - sb) >= FULL / 2) || ((sa - sb) < -(FULL / 2));
      end
      OP_AND: y = W'(a & b);
      OP_OR:  y = W'(a | b);
      OP_XOR: y = W'(a ^ b);
      OP_SHL: begin
        y = W'((a * (1 << amt)) % FULL);
        c = (amt != 0) && (((a / (1 << (W - amt))) % 2) == 1);
      end
      OP_SHR: begin
        y = W'(a / (1 << amt));
        c = (amt != 0) && (((a / (1 << (amt - 1))) % 2) == 1);
      end
      default: begin
        p = longint'(a) * longint'(b);
        y = W'(p % FULL); c = (p >= FULL);
      end
    endcase
    return {y, (y == '0), y[W-1], c, v};
  endfunction

  // Present one op, wait (bounded) for in_ready, accept, then scramble inputs.
  task automatic send(input op_t o, input logic [W-1:0] av, input logic [W-1:0] bv, output bit ok);
    int guard = 0;
    bus.in_valid = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    ok = bus.in_ready;
    if (ok) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.a  = W'($urandom);
    bus.b  = W'($urandom);
    bus.op = op_t'($urandom_range(0, 7));
  endtask

  // Count edges after acceptance until out_valid; note whether in_ready stayed low.
  task automatic wait_out(output int lat, output bit rdy_low, output bit ok);
    lat = 0; rdy_low = 1'b1;
    while (!bus.out_valid && lat < 50) begin
      if (bus.in_ready) rdy_low = 1'b0;
      @(posedge clk); #1; lat++;
    end
    ok = bus.out_valid;
  endtask

  task automatic settle();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.op = OP_ADD;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.y, bus.z, bus.n, bus.c, bus.v} !== {1'b1, 1'b0, 8'h00, 4'b1000}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b ov=%b y=%h znvc=%b%b%b%b required rdy=1 ov=0 y=00 z=1 n=0 c=0 v=0",
               bus.in_ready, bus.out_valid, bus.y, bus.z, bus.n, bus.c, bus.v);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: rdy=%b ov=%b y=%h", bus.in_ready, bus.out_valid, bus.y);
  endtask

  // One full transaction with result, latency and (for MUL) in_ready checks.
  task automatic run_checked(input string tag, input op_t o, input logic [W-1:0] av, input logic [W-1:0] bv);
    bit ok, rdy_low;
    int lat, exp_lat;
    logic [W+3:0] exp, got;
    exp     = model(o, int'(av), int'(bv));
    exp_lat = (o == OP_MUL) ? W : 0;
    send(o, av, bv, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_accept got in_ready=0 for 50 cycles required accept", tag);
      return;
    end
    wait_out(lat, rdy_low, ok);
    got = {bus.y, bus.z, bus.n, bus.c, bus.v};
    checks++;
    if (!ok || lat != exp_lat) begin
      failures++;
      $display("FAIL %s_latency got %0d required %0d", tag, lat, exp_lat);
    end
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s_result %s a=%h b=%h got y=%h zncv=%b required y=%h zncv=%b",
               tag, o.name(), av, bv, got[W+3:4], got[3:0], exp[W+3:4], exp[3:0]);
    end
    if (o == OP_MUL) begin
      checks++;
      if (!rdy_low) begin
        failures++;
        $display("FAIL %s_mul_in_ready got 1 during iteration required 0", tag);
      end
    end
    $display("%s: %s a=%h b=%h -> y=%h zncv=%b lat=%0d", tag, o.name(), av, bv, bus.y, got[3:0], lat);
  endtask

  task automatic test_directed();
    settle();
    run_checked("add_wrap", OP_ADD, 8'hFF, 8'h01);
    run_checked("sub_borrow", OP_SUB, 8'h03, 8'h05);
    run_checked("sub_ovf", OP_SUB, 8'h80, 8'h01);
    run_checked("add_ovf", OP_ADD, 8'h7F, 8'h01);
    run_checked("shr_1", OP_SHR, 8'h81, 8'h01);
    run_checked("shl_0", OP_SHL, 8'h81, 8'h00);
    run_checked("shl_7", OP_SHL, 8'h03, 8'h0F);
    run_checked("mul_hi", OP_MUL, 8'h10, 8'h10);
    run_checked("mul_ff", OP_MUL, 8'hFF, 8'hFF);
    run_checked("xor_zero", OP_XOR, 8'h5A, 8'h5A);
  endtask

  task automatic test_random();
    settle();
    for (int i = 0; i < 40; i++) begin
      run_checked("rand", op_t'($urandom_range(0, 7)), W'($urandom), W'($urandom));
    end
  endtask

  task automatic test_hold();
    bit ok;
    logic [W+3:0] exp1, exp2, got;
    settle();
    bus.out_ready = 1'b0;
    exp1 = model(OP_ADD, 8'hC3, 8'h4D);
    send(OP_ADD, 8'hC3, 8'h4D, ok);
    for (int i = 0; i < 3; i++) begin
      got = {bus.y, bus.z, bus.n, bus.c, bus.v};
      checks++;
      if (got !== exp1 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d got ov=%b rdy=%b y/f=%h required ov=1 rdy=0 y/f=%h",
                 i, bus.out_valid, bus.in_ready, got, exp1);
      end
      @(posedge clk); #1;
    end
    exp2 = model(OP_SUB, 8'h10, 8'h20);
    bus.in_valid = 1'b1; bus.op = OP_SUB; bus.a = 8'h10; bus.b = 8'h20; bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release_ready got %b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    got = {bus.y, bus.z, bus.n, bus.c, bus.v};
    checks++;
    if (got !== exp2 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL hold_b2b_accept got ov=%b y/f=%h required ov=1 y/f=%h", bus.out_valid, got, exp2);
    end
    $display("hold: released with SUB 10-20 -> y=%h", bus.y);
  endtask

  task automatic test_back_to_back();
    logic [W+3:0] exp, got;
    op_t o;
    logic [W-1:0] av, bv;
    settle();
    for (int i = 0; i < 12; i++) begin
      o  = op_t'($urandom_range(0, 6));
      av = W'($urandom); bv = W'($urandom);
      bus.in_valid = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
      exp = model(o, int'(av), int'(bv));
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready_%0d got %b required 1", i, bus.in_ready);
      end
      @(posedge clk); #1;
      got = {bus.y, bus.z, bus.n, bus.c, bus.v};
      checks++;
      if (got !== exp || bus.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_result_%0d %s a=%h b=%h got ov=%b y/f=%h required ov=1 y/f=%h",
                 i, o.name(), av, bv, bus.out_valid, got, exp);
      end
      $display("b2b: %s a=%h b=%h -> y=%h", o.name(), av, bv, bus.y);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    bit ok, seen;
    settle();
    send(OP_MUL, 8'h37, 8'h5A, ok);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.y, bus.z, bus.n, bus.c, bus.v} !== {1'b1, 1'b0, 8'h00, 4'b1000}) begin
      failures++;
      $display("FAIL mid_mul_reset got rdy=%b ov=%b y=%h zncv=%b%b%b%b required rdy=1 ov=0 y=00 zncv=1000",
               bus.in_ready, bus.out_valid, bus.y, bus.z, bus.n, bus.c, bus.v);
    end
    seen = 1'b0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL mid_mul_ghost got out_valid=1 after reset required 0");
    end
    $display("reset_mid_mul: ov=%b rdy=%b", bus.out_valid, bus.in_ready);
    run_checked("post_reset", OP_ADD, 8'h21, 8'h42);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
